// File: rtl/if_prefetch_buf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
//   - bus widths and chip-enable levels used by the fetch side
//   - fetch FSM state encoding
//   - queue entry layout {inst, pc} (64 bits)
//   - helper to word-align a redirect target
package if_prefetch_buf_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [InstAddrBus-1:0] ResetPcDefault = 32'h0000_0000;

  typedef enum logic {
    StIdle  = 1'b0,
    StFetch = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [InstBus-1:0]     inst;
    logic [InstAddrBus-1:0] pc;
  } fetch_entry_t;

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [InstAddrBus-1:0] align_pc(input logic [InstAddrBus-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Circular queue of fetched instruction entries.
//   clk, rst  : clock, asynchronous active-high reset
//   flush_i   : discard all entries (priority over push/pop)
//   push_i    : write wdata_i at tail
//   pop_i     : drop head entry
//   wdata_i   : entry to write
//   rdata_o   : head entry, reads 0 while empty
//   count_o   : number of valid entries (0..DEPTH)
// The caller guarantees push only when not full or when popping in the same cycle.
module if_prefetch_fifo
  import if_prefetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  fetch_entry_t                 wdata_i,
  output fetch_entry_t                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t mem_q [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow wraps naturally.
      if (push_i) tail_d = tail_q + PtrW'(1);
      if (pop_i)  head_d = head_q + PtrW'(1);
      if (push_i && !pop_i)      count_d = count_q + CntW'(1);
      else if (!push_i && pop_i) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the read port is gated while empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (count_q != '0) rdata_o = mem_q[head_q];
  end

  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_buf.sv
// Instruction prefetch buffer between the CPU fetch port and the instruction ROM.
//   clk, rst       : clock, asynchronous active-high reset
//   rom_ce_o       : ROM read enable, high in cycles where a word is captured
//   rom_addr_o     : ROM byte address (current fetch pc)
//   rom_data_i     : ROM read data, combinational on rom_addr_o
//   inst_valid_o   : head entry holds an instruction
//   inst_o         : head instruction word
//   inst_pc_o      : address of head instruction
//   inst_ready_i   : CPU consumes head when high with inst_valid_o
//   redirect_i     : flush queue and restart fetch at redirect_pc_i
//   redirect_pc_i  : new fetch address, low two bits ignored
module if_prefetch_buf
  import if_prefetch_buf_pkg::*;
#(
  parameter int unsigned          DEPTH    = 4,
  parameter logic [InstAddrBus-1:0] RESET_PC = ResetPcDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce_o,
  output logic [InstAddrBus-1:0] rom_addr_o,
  input  logic [InstBus-1:0]     rom_data_i,
  output logic                   inst_valid_o,
  output logic [InstBus-1:0]     inst_o,
  output logic [InstAddrBus-1:0] inst_pc_o,
  input  logic                   inst_ready_i,
  input  logic                   redirect_i,
  input  logic [InstAddrBus-1:0] redirect_pc_i
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_state_e           state_q, state_d;
  logic [InstAddrBus-1:0] fetch_pc_q, fetch_pc_d;

  logic            push;
  logic            pop;
  logic            full;
  logic [CntW-1:0] count;
  fetch_entry_t    wdata;
  fetch_entry_t    rdata;

  assign full         = (count == CntW'(DEPTH));
  assign inst_valid_o = (count != '0);

  // Redirect wins over both queue operations.
  assign pop  = inst_valid_o && inst_ready_i && !redirect_i;
  // A full queue may still accept a word if the head leaves this cycle.
  assign push = (state_q == StFetch) && !redirect_i && (!full || pop);

  assign rom_ce_o   = push ? ChipEnable : ChipDisable;
  assign rom_addr_o = fetch_pc_q;

  assign wdata.inst = rom_data_i;
  assign wdata.pc   = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: state_d = StFetch;
      default: state_d = StIdle;
    endcase
    if (redirect_i) begin
      fetch_pc_d = align_pc(redirect_pc_i);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  if_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .count_o (count)
  );

  assign inst_o    = rdata.inst;
  assign inst_pc_o = rdata.pc;

endmodule

// File: tb/tb_if_prefetch_buf.sv
module tb_if_prefetch_buf;

  localparam int unsigned    Depth   = 4;
  localparam logic [31:0]    ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard of expected {inst, pc}, pushed when a fetch is expected.
  logic [63:0] sb_q[$];
  logic        m_fetch;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {~a[15:0], a[31:16] ^ 16'hA5C3};
  endfunction

  assign rom_data_i = rom_fn(rom_addr_o);

  if_prefetch_buf #(
    .DEPTH    (Depth),
    .RESET_PC (ResetPc)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce_o      (rom_ce_o),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_fetch = 1'b0;
    m_pc    = ResetPc;
  endtask

  // Called at a negedge; drives inputs, checks outputs, advances model at posedge.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic exp_valid, exp_pop, exp_push;
    logic [63:0] head;
    inst_ready_i  = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
    exp_valid = (sb_q.size() != 0);
    head      = exp_valid ? sb_q[0] : 64'd0;
    exp_pop   = exp_valid && rdy && !redir;
    exp_push  = m_fetch && !redir && ((sb_q.size() < Depth) || exp_pop);
    check_eq("inst_valid", 64'(inst_valid_o), 64'(exp_valid));
    check_eq("inst_o", 64'(inst_o), 64'(head[63:32]));
    check_eq("inst_pc", 64'(inst_pc_o), 64'(head[31:0]));
    check_eq("rom_ce", 64'(rom_ce_o), 64'(exp_push));
    check_eq("rom_addr", 64'(rom_addr_o), 64'(m_pc));
    @(posedge clk);
    if (redir) begin
      sb_q.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (exp_pop) void'(sb_q.pop_front());
      if (exp_push) begin
        sb_q.push_back({rom_fn(m_pc), m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    m_fetch = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    #1;
    check_eq("rst_valid", 64'(inst_valid_o), 64'd0);
    check_eq("rst_inst", 64'(inst_o), 64'd0);
    check_eq("rst_pc", 64'(inst_pc_o), 64'd0);
    check_eq("rst_ce", 64'(rom_ce_o), 64'd0);
    check_eq("rst_addr", 64'(rom_addr_o), 64'(ResetPc));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Streaming with ready held high.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    // Stall: queue fills to Depth, fetch stops.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    check_eq("stall_fetch_pc", 64'(rom_addr_o), 64'(m_pc));
    check_eq("stall_count", 64'(sb_q.size()), 64'(Depth));
    // Full queue drained one per cycle while refilling.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    // Irregular consumer.
    for (int i = 0; i < 24; i++) step(1'($urandom_range(0, 1)), 1'b0, '0);

    // Redirect with three entries queued.
    step(1'b0, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    check_eq("pre_redirect_count", 64'(sb_q.size()), 64'd3);
    step(1'b0, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);

    // Address wrap at top of memory.
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Asynchronous reset pulse with two entries queued.
    step(1'b0, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0);
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(inst_valid_o), 64'd0);
    check_eq("arst_inst", 64'(inst_o), 64'd0);
    check_eq("arst_pc", 64'(inst_pc_o), 64'd0);
    check_eq("arst_ce", 64'(rom_ce_o), 64'd0);
    check_eq("arst_addr", 64'(rom_addr_o), 64'(ResetPc));
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) step(1'($urandom_range(0, 1)), 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch_buf.md
IF_PREFETCH_BUF -- requirements
Module: if_prefetch_buf

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rom_ce_o  output  1  ROM read enable; high only in cycles where a word is captured.
REQ-006 rom_addr_o  output  32 (`InstAddrBus)  ROM byte address; equals fetch_pc.
REQ-007 rom_data_i  input  32 (`InstBus)  ROM read data, combinational, valid in the same cycle as rom_addr_o.
REQ-008 inst_valid_o  output  1  queue head holds a valid instruction.
REQ-009 inst_o  output  32 (`InstBus)  head instruction word.
REQ-010 inst_pc_o  output  32 (`InstAddrBus)  address of the head instruction.
REQ-011 inst_ready_i  input  1  CPU consumes head when high together with inst_valid_o.
REQ-012 redirect_i  input  1  branch/exception redirect; flushes queue.
REQ-013 redirect_pc_i  input  32  new fetch address; bits [1:0] ignored and forced to 00.

Function
REQ-014 FSM states: IDLE (after reset, rom_ce_o=0) and FETCH; IDLE -> FETCH unconditionally on the first edge after rst deasserts; FETCH remains FETCH.
REQ-015 push = FETCH && !redirect_i && (count<DEPTH || pop); rom_ce_o = push.
REQ-016 pop = inst_valid_o && inst_ready_i && !redirect_i.
REQ-017 On push: queue entry {rom_data_i, fetch_pc} written at tail; fetch_pc <= fetch_pc + 4.
REQ-018 fetch_pc wraps modulo 2^32: 32'hFFFFFFFC + 4 -> 32'h00000000, no flag.
REQ-019 Latency: word captured at edge N is visible on inst_o/inst_pc_o with inst_valid_o=1 after edge N (empty-queue bypass not required, 1-cycle fill latency).
REQ-020 inst_o, inst_pc_o driven from the head entry registers; no combinational path from rom_data_i or inst_ready_i to them.
REQ-021 Full (count==DEPTH) with pop in the same cycle: push permitted; count unchanged.
REQ-022 Full without pop: rom_ce_o=0; fetch_pc holds.
REQ-023 Empty: inst_valid_o=0; inst_ready_i ignored.
REQ-024 Simultaneous push and pop at any count: count unchanged, pointers each advance by one, wrapping modulo DEPTH.
REQ-025 redirect_i high (priority over push/pop): count, head and tail pointers <= 0; fetch_pc <= {redirect_pc_i[31:2],2'b00}; rom_ce_o=0 that cycle; inst_valid_o=0 from the next cycle; fetching resumes the following cycle.
REQ-026 redirect_i in IDLE: fetch_pc loaded; FSM still advances to FETCH.
REQ-027 Order preserved: instructions leave in exactly the address order fetched since the last redirect/reset.

Reset
REQ-028 rst high: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, rom_ce_o=0, rom_addr_o=RESET_PC.
REQ-029 rst asserted mid-operation discards all queued entries immediately; queue storage contents need no reset beyond outputs reading 0 while empty.

Structure
REQ-030 Bus widths via `InstAddrBus/`InstBus and enables via ChipEnable/ChipDisable in shared define.v; FSM state encodings and RESET_PC default added there.
REQ-031 One sub-module, if_prefetch_fifo (parameterised DEPTH, 64-bit entries, push/pop/flush, count); the top holds FSM and fetch_pc.
REQ-032 Instantiated between openmips fetch port and inst_rom in the SOPC top.

Verification
REQ-033 Reset release, inst_ready_i=1 -> rom_addr_o 0,4,8,... from cycle 1; inst_pc_o 0,4,8 one cycle later, back-to-back.
REQ-034 inst_ready_i=0 for 10 cycles (DEPTH=4) -> exactly 4 pushes, then rom_ce_o=0, fetch_pc=16; raise ready -> pops 0,4,8,12 in order, rom_ce_o=1 in the first pop cycle.
REQ-035 Full queue, pop every cycle -> push and pop each cycle, count stays 4, no lost/duplicated PCs.
REQ-036 redirect_i with redirect_pc_i=32'h00000103 while 3 entries queued -> next cycle inst_valid_o=0, rom_ce_o=0 that cycle; then fetch addresses 0x100,0x104; first delivered inst_pc_o=0x100.
REQ-037 redirect to 32'hFFFFFFF8 -> fetch addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-038 rst pulsed asynchronously between edges with 2 entries queued -> outputs zero immediately; after release fetch restarts at RESET_PC with IDLE cycle.
